mlaccel_dispatch: RTL and testbench

- Consumes the 32-bit instruction stream emitted by the sequencer back-end (comp_valid/comp_ready/comp_data) and decodes it.
- Turns EXECUTE words into MAC-unit requests and STORE words into accumulator write-back requests.
- Tracks in-flight MAC operations, enforces SYNC barriers, and holds the vector and coefficient base registers.
- Sits between the sequencer and the MAC array / store unit.

---
 rtl/mlaccel_pkg.sv | 33 +++
 rtl/mlaccel_dispatch_slot.sv | 29 ++
 rtl/mlaccel_dispatch.sv | 181 ++++++++++++++++++
 tb/tb_mlaccel_dispatch.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlaccel_pkg.sv
// Shared instruction encoding for the sequencer and dispatch stages.
// MLACCEL_ILLEGAL_TRAP_EN adds the HALT state used by the illegal-opcode trap.
package mlaccel_pkg;

    localparam logic [5:0] OP_SYNC      = 6'd0;
    localparam logic [5:0] OP_CALL      = 6'd1;
    localparam logic [5:0] OP_RETURN    = 6'd2;
    localparam logic [5:0] OP_EXECUTE   = 6'd3;
    localparam logic [5:0] OP_SET_VBASE = 6'd4;
    localparam logic [5:0] OP_SET_CBASE = 6'd5;
    localparam logic [5:0] OP_STORE     = 6'd6;

    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 5;
    localparam int ADDR_LSB = 6;
    localparam int ADDR_MSB = 16;
    localparam int ARG_LSB  = 17;
    localparam int ARG_MSB  = 31;

`ifdef MLACCEL_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {ST_RUN, ST_SYNC_WAIT, ST_HALT} state_t;
`else
    typedef enum logic [1:0] {ST_RUN, ST_SYNC_WAIT} state_t;
`endif

    typedef struct packed {
        logic [15:0] vaddr;
        logic [15:0] caddr;
        logic        first;
        logic        last;
    } mac_req_t;

endpackage

// File: rtl/mlaccel_dispatch_slot.sv
// Single-entry valid/ready output register; a load is only issued when the
// slot is empty or draining this cycle.
module mlaccel_dispatch_slot #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic         valid_nxt,
    output logic [W-1:0] data
);

    assign valid_nxt = load || (valid && !ready);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= valid_nxt;
            if (load)
                data <= load_data;
        end
    end

endmodule

// File: rtl/mlaccel_dispatch.sv
// Instruction decode/dispatch: EXECUTE -> MAC requests, STORE -> write-back,
// SYNC barriers, base registers. MLACCEL_ILLEGAL_TRAP_EN halts on illegal opcodes.
module mlaccel_dispatch #(
    parameter int INFLIGHT_BITS = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        comp_valid,
    output logic        comp_ready,
    input  logic [31:0] comp_data,
    output logic        mac_valid,
    input  logic        mac_ready,
    output logic [15:0] mac_vaddr,
    output logic [15:0] mac_caddr,
    output logic        mac_first,
    output logic        mac_last,
    input  logic        mac_done,
    output logic        st_valid,
    input  logic        st_ready,
    output logic [15:0] st_addr,
    output logic        sync_pulse,
    output logic        busy,
    output logic        error
);
    import mlaccel_pkg::*;

    localparam logic [INFLIGHT_BITS-1:0] INFLIGHT_MAX = '1;

    state_t                   state, state_nxt;
    logic [INFLIGHT_BITS-1:0] inflight, inflight_nxt;
    logic [15:0]              vbase, cbase;
    logic                     first_pending;
    logic                     sync_nxt;

    logic [5:0]  op;
    logic [10:0] a;
    logic [14:0] arg;
    logic [15:0] a_ext;

    assign op    = comp_data[OPC_MSB:OPC_LSB];
    assign a     = comp_data[ADDR_MSB:ADDR_LSB];
    assign arg   = comp_data[ARG_MSB:ARG_LSB];
    assign a_ext = {5'b0, a};

    logic accept, exec_acc, store_acc, sync_acc, setv_acc, setc_acc, illegal_acc;
    logic mac_valid_nxt, st_valid_nxt;
    logic inc, dec;
    mac_req_t mac_load, mac_q;

    // Ready depends only on the opcode and registered state, never on comp_valid.
    always_comb begin
        comp_ready = 1'b0;
        if (state == ST_RUN) begin
            case (op)
                OP_EXECUTE: comp_ready = (!mac_valid || mac_ready) && (inflight != INFLIGHT_MAX);
                OP_STORE:   comp_ready = (inflight == '0) && !mac_valid && (!st_valid || st_ready);
                default:    comp_ready = 1'b1;
            endcase
        end
    end

    assign accept = comp_valid && comp_ready;

    always_comb begin
        exec_acc    = 1'b0;
        store_acc   = 1'b0;
        sync_acc    = 1'b0;
        setv_acc    = 1'b0;
        setc_acc    = 1'b0;
        illegal_acc = 1'b0;
        if (accept) begin
            case (op)
                OP_SYNC:            sync_acc    = 1'b1;
                OP_EXECUTE:         exec_acc    = 1'b1;
                OP_SET_VBASE:       setv_acc    = 1'b1;
                OP_SET_CBASE:       setc_acc    = 1'b1;
                OP_STORE:           store_acc   = 1'b1;
                OP_CALL, OP_RETURN: illegal_acc = 1'b1;  // resolved upstream; stray ones are errors
                default:            illegal_acc = 1'b1;
            endcase
        end
    end

    always_comb begin
        mac_load       = '0;
        mac_load.vaddr = vbase + a_ext;
        mac_load.caddr = cbase + a_ext;
        mac_load.first = first_pending;
        mac_load.last  = (arg == 15'd1);
    end

    mlaccel_dispatch_slot #(.W($bits(mac_req_t))) u_mac_slot (
        .clock     (clock),
        .resetn    (resetn),
        .load      (exec_acc),
        .load_data (mac_load),
        .ready     (mac_ready),
        .valid     (mac_valid),
        .valid_nxt (mac_valid_nxt),
        .data      (mac_q)
    );

    mlaccel_dispatch_slot #(.W(16)) u_st_slot (
        .clock     (clock),
        .resetn    (resetn),
        .load      (store_acc),
        .load_data (vbase + a_ext),
        .ready     (st_ready),
        .valid     (st_valid),
        .valid_nxt (st_valid_nxt),
        .data      (st_addr)
    );

    assign mac_vaddr = mac_q.vaddr;
    assign mac_caddr = mac_q.caddr;
    assign mac_first = mac_q.first;
    assign mac_last  = mac_q.last;

    // A retire pulse with nothing outstanding is ignored rather than wrapping.
    assign inc = exec_acc;
    assign dec = mac_done && (inflight != '0);

    always_comb begin
        inflight_nxt = inflight;
        if (inc && !dec)
            inflight_nxt = inflight + INFLIGHT_BITS'(1);
        else if (!inc && dec)
            inflight_nxt = inflight - INFLIGHT_BITS'(1);
    end

    always_comb begin
        state_nxt = state;
        sync_nxt  = 1'b0;
        case (state)
            ST_RUN: begin
                if (sync_acc)
                    state_nxt = ST_SYNC_WAIT;
`ifdef MLACCEL_ILLEGAL_TRAP_EN
                if (illegal_acc)
                    state_nxt = ST_HALT;
`endif
            end
            ST_SYNC_WAIT: begin
                if ((inflight == '0) && !mac_valid && !st_valid) begin
                    state_nxt = ST_RUN;
                    sync_nxt  = 1'b1;
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_RUN;
            inflight      <= '0;
            vbase         <= '0;
            cbase         <= '0;
            first_pending <= 1'b1;
            error         <= 1'b0;
            sync_pulse    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state      <= state_nxt;
            inflight   <= inflight_nxt;
            sync_pulse <= sync_nxt;
            if (setv_acc)
                vbase <= {arg, 1'b0};
            if (setc_acc)
                cbase <= {arg, 1'b0};
            if (exec_acc)
                first_pending <= 1'b0;
            else if (store_acc)
                first_pending <= 1'b1;
            if (illegal_acc)
                error <= 1'b1;
            busy <= (state_nxt != ST_RUN) || mac_valid_nxt || st_valid_nxt || (inflight_nxt != '0);
        end
    end

endmodule

// File: tb/tb_mlaccel_dispatch.sv
// Directed bench for mlaccel_dispatch with a queue-based reference model
// checked every cycle on the falling edge.
module tb_mlaccel_dispatch;

    localparam int IB   = 2;
    localparam int MAXI = (1 << IB) - 1;
`ifdef MLACCEL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock, resetn;
    logic        comp_valid, comp_ready;
    logic [31:0] comp_data;
    logic        mac_valid, mac_ready, mac_first, mac_last, mac_done;
    logic [15:0] mac_vaddr, mac_caddr;
    logic        st_valid, st_ready;
    logic [15:0] st_addr;
    logic        sync_pulse, busy, error;

    mlaccel_dispatch #(.INFLIGHT_BITS(IB)) dut (
        .clock(clock), .resetn(resetn),
        .comp_valid(comp_valid), .comp_ready(comp_ready), .comp_data(comp_data),
        .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_vaddr(mac_vaddr),
        .mac_caddr(mac_caddr), .mac_first(mac_first), .mac_last(mac_last),
        .mac_done(mac_done), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .sync_pulse(sync_pulse), .busy(busy), .error(error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] v;
        logic [15:0] c;
        logic        f;
        logic        l;
    } mreq_t;

    mreq_t       qm[$];
    logic [15:0] qs[$];
    int          m_inf = 0;
    logic [15:0] m_vbase = '0, m_cbase = '0;
    logic        m_first = 1'b1, m_err = 1'b0, m_halt = 1'b0, m_wait = 1'b0, m_pulse = 1'b0;
    int          n_mac_hs = 0, n_first = 0, n_last = 0, n_sync = 0;

    logic [5:0]  mon_op;
    logic [10:0] mon_a;
    logic [14:0] mon_arg;
    logic        mon_acc, mon_pulse, mon_dec;
    mreq_t       mon_r;

    function automatic logic exp_ready(input logic [5:0] op);
        if (m_wait || m_halt)
            return 1'b0;
        case (op)
            6'd3:    return (qm.size() == 0 || mac_ready) && (m_inf != MAXI);
            6'd6:    return (m_inf == 0) && (qm.size() == 0) && (qs.size() == 0 || st_ready);
            default: return 1'b1;
        endcase
    endfunction

    always @(negedge clock) begin
        if (!resetn) begin
            chk("rst_mac_valid", mac_valid, 0);
            chk("rst_st_valid", st_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_error", error, 0);
            chk("rst_sync_pulse", sync_pulse, 0);
            qm.delete();
            qs.delete();
            m_inf = 0; m_vbase = '0; m_cbase = '0; m_first = 1'b1;
            m_err = 1'b0; m_halt = 1'b0; m_wait = 1'b0; m_pulse = 1'b0;
        end else begin
            chk("mac_valid", mac_valid, qm.size() != 0);
            if (mac_valid && qm.size() != 0) begin
                chk("mac_vaddr", mac_vaddr, qm[0].v);
                chk("mac_caddr", mac_caddr, qm[0].c);
                chk("mac_first", mac_first, qm[0].f);
                chk("mac_last", mac_last, qm[0].l);
            end
            chk("st_valid", st_valid, qs.size() != 0);
            if (st_valid && qs.size() != 0)
                chk("st_addr", st_addr, qs[0]);
            chk("error", error, m_err);
            chk("sync_pulse", sync_pulse, m_pulse);
            chk("busy", busy, m_wait || m_halt || qm.size() != 0 || qs.size() != 0 || m_inf != 0);
            mon_op  = comp_data[5:0];
            mon_a   = comp_data[16:6];
            mon_arg = comp_data[31:17];
            if (comp_valid)
                chk("comp_ready", comp_ready, exp_ready(mon_op));
            mon_acc = comp_valid && comp_ready;

            if (mac_valid && mac_ready) begin
                n_mac_hs++;
                if (mac_first) n_first++;
                if (mac_last) n_last++;
            end
            if (sync_pulse) n_sync++;

            mon_pulse = m_wait && m_inf == 0 && qm.size() == 0 && qs.size() == 0;
            if (mon_pulse) m_wait = 1'b0;
            if (qm.size() != 0 && mac_ready) void'(qm.pop_front());
            if (qs.size() != 0 && st_ready) void'(qs.pop_front());
            mon_dec = mac_done && m_inf != 0;
            if (mon_acc) begin
                case (mon_op)
                    6'd0: m_wait = 1'b1;
                    6'd3: begin
                        mon_r.v = m_vbase + {5'b0, mon_a};
                        mon_r.c = m_cbase + {5'b0, mon_a};
                        mon_r.f = m_first;
                        mon_r.l = (mon_arg == 15'd1);
                        qm.push_back(mon_r);
                        m_first = 1'b0;
                        m_inf++;
                    end
                    6'd4: m_vbase = {mon_arg, 1'b0};
                    6'd5: m_cbase = {mon_arg, 1'b0};
                    6'd6: begin
                        qs.push_back(m_vbase + {5'b0, mon_a});
                        m_first = 1'b1;
                    end
                    default: begin
                        m_err = 1'b1;
                        if (TRAP) m_halt = 1'b1;
                    end
                endcase
            end
            if (mon_dec) m_inf--;
            m_pulse = mon_pulse;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] mk(input int op, input int a, input int arg);
        return {arg[14:0], a[10:0], op[5:0]};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] w, output int waited);
        waited = 0;
        comp_valid = 1'b1;
        comp_data  = w;
        @(negedge clock);
        while (!comp_ready && waited < 60) begin
            waited++;
            @(negedge clock);
        end
        if (!comp_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: word %08h ready=%0b, expected 1", w, comp_ready);
        end
        @(posedge clock);
        #1 comp_valid = 1'b0;
    endtask

    task automatic done_pulse();
        @(posedge clock);
        #1 mac_done = 1'b1;
        @(posedge clock);
        #1 mac_done = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        comp_valid = 1'b0;
        mac_done = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int wt, h0, f0, l0, s0;

    initial begin
        resetn = 1'b0; comp_valid = 1'b0; comp_data = '0;
        mac_ready = 1'b0; st_ready = 1'b1; mac_done = 1'b0;
        @(negedge clock);
        chk("rst_comp_ready", comp_ready, 1);
        chk("rst_mac_vaddr", mac_vaddr, 16'h0000);
        chk("rst_st_addr", st_addr, 16'h0000);
        apply_reset();

        // Base registers + single EXECUTE, MAC unit stalled
        send(mk(4, 0, 15'h0100), wt);
        send(mk(5, 0, 15'h0800), wt);
        send(mk(3, 5, 1), wt);
        @(negedge clock);
        chk("t1_valid", mac_valid, 1);
        chk("t1_vaddr", mac_vaddr, 16'h0205);
        chk("t1_caddr", mac_caddr, 16'h1005);
        chk("t1_first", mac_first, 1);
        chk("t1_last", mac_last, 1);
        @(negedge clock);
        chk("t1_hold", mac_valid, 1);
        // Asynchronous reset while the request is still pending
        #3 resetn = 1'b0;
        #1;
        chk("t1_async_mac_valid", mac_valid, 0);
        chk("t1_async_busy", busy, 0);
        apply_reset();

        // Three back-to-back EXECUTEs
        mac_ready = 1'b1;
        h0 = n_mac_hs; f0 = n_first; l0 = n_last;
        send(mk(3, 1, 3), wt);
        send(mk(3, 2, 2), wt);
        send(mk(3, 3, 1), wt);
        @(posedge clock);
        #1;
        chk("t2_mac_count", n_mac_hs - h0, 3);
        chk("t2_first_count", n_first - f0, 1);
        chk("t2_last_count", n_last - l0, 1);
        chk("t2_model_inflight", m_inf, 3);
        repeat (4) done_pulse();  // one extra pulse exercises the no-underflow rule
        @(negedge clock);
        chk("t2_drain_busy", busy, 0);
        @(posedge clock);
        #1;

        // In-flight limit stall
        apply_reset();
        send(mk(3, 0, 1), wt);
        send(mk(3, 1, 1), wt);
        send(mk(3, 2, 1), wt);
        comp_valid = 1'b1;
        comp_data = mk(3, 3, 1);
        repeat (3) begin
            @(negedge clock);
            chk("t3_stall_ready", comp_ready, 0);
            @(posedge clock);
            #1;
        end
        mac_done = 1'b1;
        @(negedge clock);
        chk("t3_done_cycle_ready", comp_ready, 0);
        @(posedge clock);
        #1 mac_done = 1'b0;
        @(negedge clock);
        chk("t3_after_done_ready", comp_ready, 1);
        @(posedge clock);
        #1 comp_valid = 1'b0;
        repeat (3) done_pulse();

        // STORE waits for retirement, then re-arms mac_first
        apply_reset();
        send(mk(4, 0, 15'h0010), wt);
        send(mk(3, 0, 1), wt);
        fork
            send(mk(6, 7, 0), wt);
            begin
                repeat (10) @(posedge clock);
                #1 mac_done = 1'b1;
                @(posedge clock);
                #1 mac_done = 1'b0;
            end
        join
        chk("t4_store_waited", wt >= 10, 1);
        @(negedge clock);
        chk("t4_st_valid", st_valid, 1);
        chk("t4_st_addr", st_addr, 16'h0027);
        @(posedge clock);
        #1;
        send(mk(3, 1, 1), wt);
        @(negedge clock);
        chk("t4_refirst", mac_first, 1);
        @(posedge clock);
        #1;
        send(mk(4, 0, 15'h7FFF), wt);
        send(mk(3, 5, 2), wt);
        @(negedge clock);
        chk("t4_wrap_vaddr", mac_vaddr, 16'h0003);
        chk("t4_wrap_first", mac_first, 0);
        chk("t4_wrap_last", mac_last, 0);
        @(posedge clock);
        #1;

        // SYNC barrier with two ops outstanding
        apply_reset();
        send(mk(3, 0, 2), wt);
        send(mk(3, 1, 1), wt);
        s0 = n_sync;
        send(mk(0, 0, 0), wt);
        comp_valid = 1'b1;
        comp_data = mk(4, 0, 15'h0022);
        @(negedge clock);
        chk("t5_wait_ready_a", comp_ready, 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("t5_wait_ready_b", comp_ready, 0);
        @(posedge clock);
        #1;
        done_pulse();
        done_pulse();
        send(mk(4, 0, 15'h0022), wt);
        chk("t5_sync_count", n_sync - s0, 1);
        repeat (3) @(posedge clock);
        #1;
        chk("t5_sync_once", n_sync - s0, 1);

        // Illegal opcode
        apply_reset();
        send(mk(9, 0, 0), wt);
        @(negedge clock);
        chk("t6_error", error, 1);
        @(posedge clock);
        #1;
`ifdef MLACCEL_ILLEGAL_TRAP_EN
        comp_valid = 1'b1;
        comp_data = mk(3, 0, 1);
        repeat (3) begin
            @(negedge clock);
            chk("t6_halt_ready", comp_ready, 0);
            chk("t6_halt_busy", busy, 1);
            @(posedge clock);
            #1;
        end
        comp_valid = 1'b0;
`else
        send(mk(3, 4, 1), wt);
        @(negedge clock);
        chk("t6_continue_mac", mac_valid, 1);
        chk("t6_continue_error", error, 1);
        @(posedge clock);
        #1;
        done_pulse();
`endif
        apply_reset();
        @(negedge clock);
        chk("t6_reset_error", error, 0);
        chk("t6_reset_busy", busy, 0);
        comp_data = mk(3, 0, 1);
        comp_valid = 1'b1;
        @(negedge clock);
        chk("t6_reset_ready", comp_ready, 1);
        @(posedge clock);
        #1 comp_valid = 1'b0;
        repeat (3) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
